// File: rtl/fetch_pc_stage_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pc_stage_pkg : shared constants and state encoding for the fetch stage
// Revision: 1.0
// ============================================================================
package fetch_pc_stage_pkg;

   localparam int          STALL_BUS    = 6;
   localparam int          STALL_PC     = 0;
   localparam int          STALL_IF     = 1;
   localparam logic [31:0] RESET_PC_DEF = 32'h1bff_fffc;
   localparam logic [31:0] INST_NOP     = 32'h0340_0000;

   // State is exactly the pair {pend_valid, ibuf_valid}.
   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_HOLD       = 2'b01,
      ST_REDIR      = 2'b10,
      ST_HOLD_REDIR = 2'b11
   } fs_state_e;

   function automatic fs_state_e fs_state_enc(input logic redir, input logic hold);
      fs_state_e s;
      case ({redir, hold})
         2'b00:   s = ST_RUN;
         2'b01:   s = ST_HOLD;
         2'b10:   s = ST_REDIR;
         default: s = ST_HOLD_REDIR;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_inst_buf.sv
`default_nettype none
// ============================================================================
// fetch_inst_buf : holds SRAM read data across an IF stall and selects the
//                  word presented to decode.
// Revision: 1.0
// ============================================================================
module fetch_inst_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        capture,
   input  logic        sel,
   input  logic        zero,
   input  logic [31:0] rdata,
   output logic [31:0] inst
);

   logic [31:0] ibuf_q;
   logic [31:0] ibuf_d;

   always_comb begin
      ibuf_d = ibuf_q;
      if (capture) begin
         ibuf_d = rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ibuf_q <= 32'h0;
      end else begin
         ibuf_q <= ibuf_d;
      end
   end

   assign inst = zero ? 32'h0 : (sel ? ibuf_q : rdata);

endmodule
`default_nettype wire

// File: rtl/fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// fetch_pc_stage : PC generation, instruction SRAM drive and IF->ID handoff.
// Optional feature macro: FETCH_ADEF_EN (misaligned fetch address exception).
// Revision: 1.0
// ============================================================================
module fetch_pc_stage
   import fetch_pc_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [STALL_BUS-1:0] stall,
   input  logic                 flush,
   input  logic [31:0]          flush_pc,
   input  logic                 br_taken,
   input  logic [31:0]          br_target,
   output logic                 inst_sram_en,
   output logic [31:0]          inst_sram_addr,
   input  logic [31:0]          inst_sram_rdata,
   output logic                 fs_to_ds_valid,
   output logic [31:0]          fs_pc,
   output logic [31:0]          fs_inst,
   output logic                 fs_excp_adef
);

   fs_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic        fs_valid_q, fs_valid_d;
   logic        cancel_q, cancel_d;
   logic        adef_q, adef_d;
   logic        hold_q, redir_q, hold_d, redir_d;
   logic        ibuf_capture;
   logic        pc_load;
   logic        misaligned;
   logic [31:0] nextpc;
   logic        stall_unused;

   assign stall_unused = ^stall[STALL_BUS-1:STALL_IF+1];

   assign hold_q  = (state_q == ST_HOLD)  || (state_q == ST_HOLD_REDIR);
   assign redir_q = (state_q == ST_REDIR) || (state_q == ST_HOLD_REDIR);

   always_comb begin
      if (flush) begin
         nextpc = flush_pc;
      end else if (redir_q) begin
         nextpc = pend_target_q;
      end else if (br_taken) begin
         nextpc = br_target;
      end else begin
         nextpc = pc_q + 32'd4;
      end
   end

   // A latched address error freezes the PC until the flush that handles it.
   assign pc_load = flush | (!stall[STALL_PC] & !adef_q);

`ifdef FETCH_ADEF_EN
   assign misaligned   = (nextpc[1:0] != 2'b00);
   assign fs_excp_adef = adef_q;
`else
   assign misaligned   = 1'b0;
   assign fs_excp_adef = 1'b0;
`endif

   assign inst_sram_en   = !reset & pc_load & !misaligned;
   assign inst_sram_addr = nextpc;

   always_comb begin
      pc_d          = pc_q;
      fs_valid_d    = fs_valid_q;
      adef_d        = adef_q;
      pend_target_d = pend_target_q;
      cancel_d      = cancel_q;
      redir_d       = redir_q;
      hold_d        = !flush & stall[STALL_IF];
      ibuf_capture  = !flush & stall[STALL_IF] & !hold_q;

      if (pc_load) begin
         pc_d       = nextpc;
         fs_valid_d = 1'b1;
         adef_d     = misaligned;
      end

      if (flush) begin
         redir_d  = 1'b0;
         cancel_d = 1'b0;
      end else if (br_taken && stall[STALL_PC]) begin
         redir_d       = 1'b1;
         cancel_d      = 1'b1;
         pend_target_d = br_target;
      end else if (redir_q && pc_load) begin
         redir_d  = 1'b0;
         cancel_d = 1'b0;
      end

      state_d = fs_state_enc(redir_d, hold_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         pend_target_q <= 32'h0;
         fs_valid_q    <= 1'b0;
         cancel_q      <= 1'b0;
         adef_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         fs_valid_q    <= fs_valid_d;
         cancel_q      <= cancel_d;
         adef_q        <= adef_d;
      end
   end

   assign fs_to_ds_valid = fs_valid_q & !flush & !br_taken & !redir_q & !cancel_q;
   assign fs_pc          = pc_q;

   fetch_inst_buf u_inst_buf (
      .clk     (clk),
      .reset   (reset),
      .capture (ibuf_capture),
      .sel     (hold_q),
      .zero    (adef_q),
      .rdata   (inst_sram_rdata),
      .inst    (fs_inst)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_pc_stage : directed vector table plus hand sequences for fetch_pc_stage.
// Revision: 1.0
// ============================================================================
module tb_fetch_pc_stage;

   localparam logic [31:0] RST = 32'h1bff_fffc;
   localparam logic [31:0] B   = 32'h1c00_0000;
   localparam logic [31:0] F1  = 32'h1c00_8000;
   localparam logic [31:0] F2  = 32'h1c00_a000;
   localparam logic [5:0]  S0  = 6'b000000;
   localparam logic [5:0]  S3  = 6'b000011;
   localparam logic [5:0]  S7  = 6'b000111;

   logic        clk;
   logic        reset;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        fs_excp_adef;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] garb = 32'h0;

   typedef struct {
      logic [5:0]  st;
      logic        fl;
      logic [31:0] fpc;
      logic        br;
      logic [31:0] bt;
      logic        en;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic        ci;
      logic [31:0] ia;
   } vec_t;

   vec_t vecs[$];

   fetch_pc_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .flush           (flush),
      .flush_pc        (flush_pc),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_pc           (fs_pc),
      .fs_inst         (fs_inst),
      .fs_excp_adef    (fs_excp_adef)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5a5a_5a5a;
   endfunction

   // Synchronous SRAM: data one cycle after enable, garbage otherwise.
   initial inst_sram_rdata = 32'h0;
   always @(posedge clk) begin
      garb <= garb + 32'd1;
      if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
      else              inst_sram_rdata <= 32'hbad0_0000 | garb;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] st, input logic fl, input logic [31:0] fpc,
                      input logic br, input logic [31:0] bt, input logic en,
                      input logic [31:0] addr, input logic vld, input logic [31:0] pc,
                      input logic ci, input logic [31:0] ia);
      vec_t v;
      v.st = st; v.fl = fl; v.fpc = fpc; v.br = br; v.bt = bt;
      v.en = en; v.addr = addr; v.vld = vld; v.pc = pc; v.ci = ci; v.ia = ia;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [5:0] st, input logic fl, input logic [31:0] fpc,
                        input logic br, input logic [31:0] bt);
      stall = st; flush = fl; flush_pc = fpc; br_taken = br; br_target = bt;
   endtask

   initial begin
      reset = 1'b1;
      drive(S0, 1'b0, 32'h0, 1'b0, 32'h0);

      //   stall fl  flush_pc      br  br_target    en  addr           vld pc             ci  inst addr
      add(S0,   0, 32'h0,        0, 32'h0,       1, B,             0, RST,           0, 32'h0);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+4,           1, B,             1, B);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+8,           1, B+4,           1, B+4);
      add(S3,   0, 32'h0,        0, 32'h0,       0, B+12,          1, B+8,           1, B+8);
      add(S3,   0, 32'h0,        0, 32'h0,       0, B+12,          1, B+8,           1, B+8);
      add(S3,   0, 32'h0,        0, 32'h0,       0, B+12,          1, B+8,           1, B+8);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+12,          1, B+8,           1, B+8);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+16,          1, B+12,          1, B+12);
      add(S0,   0, 32'h0,        1, B+32'h100,   1, B+32'h100,     0, B+16,          0, 32'h0);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+32'h104,     1, B+32'h100,     1, B+32'h100);
      add(S7,   0, 32'h0,        1, B+32'h200,   0, B+32'h200,     0, B+32'h104,     0, 32'h0);
      add(S7,   0, 32'h0,        1, B+32'h200,   0, B+32'h200,     0, B+32'h104,     0, 32'h0);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+32'h200,     0, B+32'h104,     0, 32'h0);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+32'h204,     1, B+32'h200,     1, B+32'h200);
      add(S3,   0, 32'h0,        1, B+32'h300,   0, B+32'h300,     0, B+32'h204,     0, 32'h0);
      add(S3,   1, F1,           0, 32'h0,       1, F1,            0, B+32'h204,     0, 32'h0);
      add(S0,   0, 32'h0,        0, 32'h0,       1, F1+4,          1, F1,            1, F1);
      add(S0,   0, 32'h0,        0, 32'h0,       1, F1+8,          1, F1+4,          1, F1+4);
      add(S3,   1, F2,           0, 32'h0,       1, F2,            0, F1+8,          0, 32'h0);
      add(S3,   0, 32'h0,        0, 32'h0,       0, F2+4,          1, F2,            1, F2);
      add(S3,   0, 32'h0,        0, 32'h0,       0, F2+4,          1, F2,            1, F2);
      add(S0,   0, 32'h0,        0, 32'h0,       1, F2+4,          1, F2,            1, F2);
      add(S0,   0, 32'h0,        0, 32'h0,       1, F2+8,          1, F2+4,          1, F2+4);
      add(S0,   1, 32'hffff_fffc,0, 32'h0,       1, 32'hffff_fffc, 0, F2+8,          0, 32'h0);
      add(S0,   0, 32'h0,        0, 32'h0,       1, 32'h0,         1, 32'hffff_fffc, 1, 32'hffff_fffc);
      add(S0,   0, 32'h0,        0, 32'h0,       1, 32'h4,         1, 32'h0,         1, 32'h0);
      add(S0,   1, B+32'h400,    1, B+32'h500,   1, B+32'h400,     0, 32'h4,         0, 32'h0);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+32'h404,     1, B+32'h400,     1, B+32'h400);
      add(6'b111100, 0, 32'h0,   0, 32'h0,       1, B+32'h408,     1, B+32'h404,     1, B+32'h404);
      add(S0,   0, 32'h0,        0, 32'h0,       1, B+32'h40c,     1, B+32'h408,     1, B+32'h408);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset en",    {31'h0, inst_sram_en},   32'h0);
      check("reset valid", {31'h0, fs_to_ds_valid}, 32'h0);
      check("reset pc",    fs_pc,                   RST);
      check("reset adef",  {31'h0, fs_excp_adef},   32'h0);

      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].st, vecs[i].fl, vecs[i].fpc, vecs[i].br, vecs[i].bt);
         @(negedge clk);
         check($sformatf("row%0d en", i),    {31'h0, inst_sram_en},   {31'h0, vecs[i].en});
         check($sformatf("row%0d addr", i),  inst_sram_addr,          vecs[i].addr);
         check($sformatf("row%0d valid", i), {31'h0, fs_to_ds_valid}, {31'h0, vecs[i].vld});
         check($sformatf("row%0d pc", i),    fs_pc,                   vecs[i].pc);
         check($sformatf("row%0d adef", i),  {31'h0, fs_excp_adef},   32'h0);
         if (vecs[i].ci) check($sformatf("row%0d inst", i), fs_inst, inst_of(vecs[i].ia));
         @(posedge clk); #1;
      end

      // Asynchronous reset in the middle of a stalled redirect.
      drive(S7, 1'b0, 32'h0, 1'b1, B+32'h600);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      check("midreset en",    {31'h0, inst_sram_en},   32'h0);
      check("midreset valid", {31'h0, fs_to_ds_valid}, 32'h0);
      check("midreset pc",    fs_pc,                   RST);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(S0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("postreset addr", inst_sram_addr,          B);
      check("postreset en",   {31'h0, inst_sram_en},   32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      check("postreset pc",    fs_pc,                   B);
      check("postreset valid", {31'h0, fs_to_ds_valid}, 32'h1);
      check("postreset inst",  fs_inst,                 inst_of(B));

      // Branch to a misaligned target.
      @(posedge clk); #1;
      drive(S0, 1'b0, 32'h0, 1'b1, B+32'h102);
      @(negedge clk);
      check("mis addr", inst_sram_addr, B+32'h102);
`ifdef FETCH_ADEF_EN
      check("mis en", {31'h0, inst_sram_en}, 32'h0);
      @(posedge clk); #1;
      drive(S0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("adef flag",  {31'h0, fs_excp_adef},   32'h1);
      check("adef pc",    fs_pc,                   B+32'h102);
      check("adef valid", {31'h0, fs_to_ds_valid}, 32'h1);
      check("adef inst",  fs_inst,                 32'h0);
      check("adef en",    {31'h0, inst_sram_en},   32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("adef hold pc", fs_pc,                 B+32'h102);
      check("adef hold en", {31'h0, inst_sram_en}, 32'h0);
      @(posedge clk); #1;
      drive(S0, 1'b1, B, 1'b0, 32'h0);
      @(negedge clk);
      check("adef flush en", {31'h0, inst_sram_en}, 32'h1);
      @(posedge clk); #1;
      drive(S0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("adef cleared",  {31'h0, fs_excp_adef}, 32'h0);
      check("adef flush pc", fs_pc,                 B);
`else
      check("mis en", {31'h0, inst_sram_en}, 32'h1);
      @(posedge clk); #1;
      drive(S0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("mis pc",    fs_pc,                   B+32'h102);
      check("mis adef",  {31'h0, fs_excp_adef},   32'h0);
      check("mis valid", {31'h0, fs_to_ds_valid}, 32'h1);
      check("mis inst",  fs_inst,                 inst_of(B+32'h102));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Fetch stage of the in-order LoongArch pipeline. Generates the next PC, drives the synchronous instruction SRAM, and presents the fetched instruction to the decode stage. Consumes `stall`/`flush` from the pipeline controller, and consumes branch redirects from decode. Holds SRAM read data across stalls, and holds redirects that arrive while fetch is frozen.

## Interface
Parameters:
- `RESET_PC`, default `32'h1bfff_ffc`: PC register value in reset. The first fetch address is `RESET_PC+4` = `32'h1c00_0000`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `stall` in 6: from the pipeline controller. Bit 0 freezes the PC; bit 1 freezes the IF→ID handoff. Bits 5:2 are ignored.
- `flush` in 1: exception/ertn redirect; a single-cycle pulse.
- `flush_pc` in 32: redirect target, valid while `flush`=1.
- `br_taken` in 1: taken branch/jump resolved in decode.
- `br_target` in 32: branch target, valid while `br_taken`=1.
- `inst_sram_en` out 1: read enable.
- `inst_sram_addr` out 32: read address (`nextpc`).
- `inst_sram_rdata` in 32: read data, returned one cycle after the enable.
- `fs_to_ds_valid` out 1: instruction on `fs_inst`/`fs_pc` is valid for decode.
- `fs_pc` out 32: PC of the presented instruction.
- `fs_inst` out 32: the presented instruction.
- `fs_excp_adef` out 1: fetch address error (only when `FETCH_ADEF_EN` is defined; otherwise tied to 0).

## Operation
- **PC and SRAM drive**
  - `pc` register holds the address of the instruction in flight; `nextpc` is combinational.
  - `nextpc` priority: `flush` → `flush_pc`; else pending redirect → `pend_target`; else `br_taken` → `br_target`; else `pc+4`. The `+4` wraps modulo 2^32.
  - `inst_sram_en` = `!stall[0]` & `!reset`.
  - `inst_sram_addr` = `nextpc`.
  - `pc` ← `nextpc` when `!stall[0]`, or when `flush` is high regardless of `stall[0]`.
- **Validity**
  - `fs_valid` sets the cycle after the first enabled fetch following reset.
  - `fs_to_ds_valid` = `fs_valid` & `!flush` & `!br_taken` & `!pend_valid` & `!cancel`.
  - The instruction in IF during a redirect is wrong-path and is never delivered.
- **Hold buffer**
  - Applies when `stall[1]`=1 and the buffer is empty in the first stall cycle: capture `inst_sram_rdata` into `ibuf` and set `ibuf_valid`.
  - `fs_inst` = `ibuf_valid ? ibuf : inst_sram_rdata`.
  - `ibuf_valid` clears on the first cycle with `stall[1]`=0 after that cycle is presented, or on `flush`.
- **Pending redirect**
  - Applies when `br_taken` arrives while `stall[0]`=1: latch `pend_target` and set `pend_valid`. Also set `cancel`, which suppresses delivery of the current IF instruction.
  - On the first unstalled cycle, `nextpc` = `pend_target`, then `pend_valid` clears.
  - `cancel` clears when the redirected fetch's data arrives.
  - A repeated `br_taken` during the same stall rewrites the same target harmlessly.
- **State encoding:** the two flags give 4 combinations, decoded as states RUN, HOLD (`ibuf_valid`), REDIR (`pend_valid`), HOLD_REDIR.
- **Flush** overrides everything in all states:
  - loads `pc`;
  - clears `ibuf_valid`, `pend_valid` and `cancel`;
  - asserts `inst_sram_en` even if `stall[0]` is high.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`; `fs_pc`=`RESET_PC`; `fs_inst`=0 when `ibuf` is selected.
  - `fs_to_ds_valid`=0, `inst_sram_en`=0, `fs_excp_adef`=0.
  - All flags 0.
- **First fetch:** the first rising edge after `reset` deasserts issues address `32'h1c00_0000`; `fs_to_ds_valid`=1 one cycle later.
- **Fetch latency:** 1 cycle from address to `fs_inst`.
- **Taken branch:** costs 1 bubble.
- **Flush:** in the flush cycle, `inst_sram_addr`=`flush_pc` and `fs_to_ds_valid`=0. The next cycle presents `flush_pc` with valid=1, unless stalled.
- **Reset mid-stall:** all state is discarded immediately (asynchronous).

## Configuration
- `FETCH_ADEF_EN` defined:
  - `nextpc[1:0]`≠0 raises `fs_excp_adef` with the fetched PC in the following cycle, with `fs_to_ds_valid`=1 and `fs_inst`=0.
  - `inst_sram_en` is forced 0 for that address.
  - The PC does not advance further until `flush`.
- `FETCH_ADEF_EN` undefined: `fs_excp_adef`=0, and the low bits are passed to the SRAM unchanged.

## Structure
- **Shared package:**
  - `STALL_BUS`=6;
  - stall bit indices `STALL_PC`=0, `STALL_IF`=1;
  - `RESET_PC` default;
  - `INST_NOP`=`32'h0340_0000`.
- **Sub-module:** `fetch_inst_buf` (hold buffer plus select mux). The PC/redirect logic stays in the top module.

## Test plan
- **Reset release:** → `inst_sram_addr`=`1c000000`; next cycle `fs_pc`=`1c000000`, valid=1; then `1c000004`, `1c000008`.
- **Stall hold:** `stall`=`000011` for 3 cycles while `rdata` changes to garbage → `fs_inst` holds the captured word; `pc` unchanged; release resumes at `pc+4` with no loss or duplicate.
- **Taken branch:** `br_taken`, `br_target`=`1c000100` with no stall → the wrong-path instruction gets valid=0; the next delivered `fs_pc` is `1c000100`.
- **Branch during stall:** `br_taken` during `stall`=`000111` for 2 cycles → no delivery during the stall; after release, fetch from the target; exactly one bubble after release.
- **Flush during hold/redirect:** `flush`, `flush_pc`=`1c008000` while `ibuf_valid` and `pend_valid` are set → both clear; the next `fs_pc` is `1c008000`.
- **`FETCH_ADEF_EN` misaligned target:** build with `FETCH_ADEF_EN`, `br_target`=`1c000102` → `fs_excp_adef`=1 with `fs_pc`=`1c000102`; `inst_sram_en`=0 until `flush`.
